sipo_deser: RTL and testbench
=============================

Name: sipo_deser

Overview:
- Serial-in, parallel-out deserializer; the receive end of the team's MSB-first serial link.
- Collects WIDTH bits, one per qualified clock, starting at a frame-start marker.
- Presents each completed word on a registered parallel output with a valid/ready handshake.
- Flags overruns when a new word completes while the previous word is still unconsumed.

Parameters:
- WIDTH, 4, word width in bits; legal range ≥2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- s_in  input  1  serial data bit; MSB first.
- s_en  input  1  bit strobe; s_in is sampled only when s_en=1.
- frame_start  input  1  qualified by s_en; marks the current bit as the MSB of a new word.
- p_out  output  WIDTH  completed parallel word (holding register).
- p_valid  output  1  p_out holds an unconsumed word.
- p_ready  input  1  consumer accepts p_out when p_valid & p_ready.
- overrun  output  1  one-cycle pulse: a completed word was dropped.
- busy  output  1  1 while a partial word is being collected (state RECV and bit count ≠0).

Behaviour:
- All state is updated on the rising edge of clk.
- Reset: clk rising with rst=1 sets:
  - state=IDLE, bit count=0, shift register=0.
  - p_out=0, p_valid=0, overrun=0, busy=0.
  - rst has priority over every other input.
  - Reset mid-word discards the partial word.
  - Reset while p_valid=1 discards the held word.
- States: IDLE, RECV.
  - IDLE: s_en bits are ignored unless frame_start=1.
  - IDLE, s_en & frame_start: shift_reg[WIDTH-1] <= s_in, count <= 1, go to RECV.
  - RECV, s_en & !frame_start: shift in s_in at the next lower position (MSB first); count increments.
  - RECV, s_en & frame_start: partial word discarded; current bit becomes the new MSB; count <= 1; no overrun.
  - RECV, s_en=0: hold all state; count frozen; gaps of any length are allowed.
- Word completion: the s_en cycle that delivers bit index 0 (count = WIDTH-1).
  - count wraps to 0; state stays RECV.
  - Back-to-back words need no new frame_start.
  - A frame_start on any later MSB bit re-aligns the count.
- Output transfer on the completion edge:
  - If p_valid=0, or p_valid & p_ready in the same cycle: p_out <= completed word, p_valid <= 1.
  - Else the completed word is dropped, p_out is unchanged, p_valid stays 1, overrun=1 for exactly one cycle.
- Latency: p_out/p_valid update on the same edge that samples the last bit; the word is visible in the following cycle.
- Handshake:
  - p_valid & p_ready with no completion: p_valid <= 0 next edge.
  - p_out retains its last value; it is not cleared.
  - p_out is stable while p_valid=1 and p_ready=0.
- overrun is 0 on every cycle other than a dropped-word cycle.
- busy=1 iff state=RECV and count ≠0.
- s_in, frame_start and p_ready are don't-care when their qualifiers are inactive.

Test Plan:
- Reset then single frame (WIDTH=4): frame_start with bit 1, then bits 0,1,1 on consecutive s_en cycles, p_ready=1 -> p_out=4'hB with p_valid=1 for one cycle, starting the cycle after the 4th bit; busy=1 during bits 2-4, then 0.
- Gapped strobes: same bits 1,0,1,1 with s_en low for 3 cycles between each bit -> p_out=4'hB; no partial output; count frozen during gaps.
- Back-to-back and backpressure:
  - Words 4'hA then 4'h5 streamed with one frame_start, p_ready=0 -> p_out=4'hA held, p_valid=1, overrun pulses once on the 8th bit.
  - Then raise p_ready -> p_valid drops next cycle; 4'h5 is never seen.
- Accept-on-completion: p_valid=1 and p_ready=1 in the same cycle that completes 4'h3 -> p_out=4'h3, p_valid stays 1, overrun=0.
- Re-alignment: frame_start with bit 1, bit 1, then frame_start with bit 0, then bits 1,1,0 -> p_out=4'h6; the first partial word is discarded; no overrun.
- Reset mid-operation: rst asserted after 2 bits with a held word pending -> next cycle p_valid=0, p_out=0, busy=0, state=IDLE; bits sent without frame_start are ignored.

Source files
------------

// File: rtl/sipo_deser.sv
// ---------------------------------------------------------------------------
// sipo_deser -- serial-in, parallel-out deserializer (receive end of the
// MSB-first serial link).
//
// Collects WIDTH bits, one per s_en strobe, starting at a frame_start marker.
// Each completed word is loaded into a holding register and offered downstream
// with a valid/ready handshake. If a word completes while the held word is
// still unconsumed, the new word is dropped and overrun pulses for one cycle.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   s_in         serial data bit, MSB first (sampled only when s_en=1)
//   s_en         bit strobe
//   frame_start  qualified by s_en; current bit is the MSB of a new word
//   p_out        completed parallel word (holding register)
//   p_valid      p_out holds an unconsumed word
//   p_ready      consumer accepts p_out when p_valid & p_ready
//   overrun      one-cycle pulse: a completed word was dropped
//   busy         a partial word is being collected (RECV and count != 0)
//   dbg_state_o  current FSM state (0 = IDLE, 1 = RECV)
//
// Handshake: a transfer happens on every rising edge where p_valid=1 and
// p_ready=1. p_valid never drops without a transfer, and p_out is stable
// while p_valid=1 and p_ready=0. A word completing in the same cycle as a
// transfer replaces the accepted word, so p_valid stays high.
// ---------------------------------------------------------------------------
module sipo_deser #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_in,
    input  logic             s_en,
    input  logic             frame_start,
    output logic [WIDTH-1:0] p_out,
    output logic             p_valid,
    input  logic             p_ready,
    output logic             overrun,
    output logic             busy,
    output logic             dbg_state_o
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] p_out_q, p_out_d;
    logic             p_valid_q, p_valid_d;
    logic             overrun_q, overrun_d;

    // Position in the shift register that the current bit lands in (MSB first).
    logic [CW-1:0]    bit_idx;
    logic             word_done;
    logic [WIDTH-1:0] word;

    assign bit_idx   = CW'(WIDTH - 1) - count_q;
    // The strobe carrying bit 0 completes the word; a frame_start on that
    // strobe re-aligns instead, so it never completes.
    assign word_done = (state_q == RECV) && s_en && !frame_start
                       && (count_q == CW'(WIDTH - 1));
    assign word      = {shift_q[WIDTH-1:1], s_in};

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            shift_q   <= '0;
            p_out_q   <= '0;
            p_valid_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            shift_q   <= shift_d;
            p_out_q   <= p_out_d;
            p_valid_q <= p_valid_d;
            overrun_q <= overrun_d;
        end
    end

    // ---------------- next-state logic ----------------
    // Once aligned the receiver stays in RECV; only reset returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (s_en && frame_start) state_d = RECV;
            RECV:    state_d = RECV;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- datapath next-state ----------------
    always_comb begin
        count_d   = count_q;
        shift_d   = shift_q;
        p_out_d   = p_out_q;
        p_valid_d = p_valid_q;
        overrun_d = 1'b0;

        if (s_en) begin
            if (frame_start) begin
                // Start or re-align: current bit is the new MSB, partial word discarded.
                shift_d[WIDTH-1] = s_in;
                count_d          = CW'(1);
            end else if (state_q == RECV) begin
                shift_d[bit_idx] = s_in;
                if (word_done) count_d = '0;
                else           count_d = count_q + CW'(1);
            end
        end

        if (word_done) begin
            if (!p_valid_q || p_ready) begin
                p_out_d   = word;
                p_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (p_valid_q && p_ready) begin
            p_valid_d = 1'b0;
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        busy        = (state_q == RECV) && (count_q != '0);
        dbg_state_o = state_q;
    end

    assign p_out   = p_out_q;
    assign p_valid = p_valid_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_sipo_deser.sv
// Directed bench for sipo_deser (WIDTH=4). Inputs are driven 1 ns after the
// rising edge; outputs are checked after that same settle point.
module tb_sipo_deser;

  localparam int W = 4;

  // ---------------- clock / reset ----------------
  logic         clk;
  logic         rst;
  logic         s_in;
  logic         s_en;
  logic         frame_start;
  logic [W-1:0] p_out;
  logic         p_valid;
  logic         p_ready;
  logic         overrun;
  logic         busy;
  logic         dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sipo_deser #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .s_in        (s_in),
    .s_en        (s_en),
    .frame_start (frame_start),
    .p_out       (p_out),
    .p_valid     (p_valid),
    .p_ready     (p_ready),
    .overrun     (overrun),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pops the next expected word and compares it to the held output.
  task automatic check_word(input string tag);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check(tag, 32'(p_out), 32'(e));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic fs);
    s_en        = 1'b1;
    s_in        = b;
    frame_start = fs;
    tick();
    s_en        = 1'b0;
    frame_start = 1'b0;
    s_in        = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; s_in = 1'b0; s_en = 1'b0; frame_start = 1'b0; p_ready = 1'b0;
    #1;
    idle(2);
    rst = 1'b0;

    // Reset state
    check("rst_p_out",   32'(p_out),     32'h0);
    check("rst_p_valid", 32'(p_valid),   32'h0);
    check("rst_overrun", 32'(overrun),   32'h0);
    check("rst_busy",    32'(busy),      32'h0);
    check("rst_state",   32'(dbg_state), 32'h0);

    // Single frame 1,0,1,1 -> B
    p_ready = 1'b1;
    exp_q.push_back(4'hB);
    send_bit(1'b1, 1'b1);
    check("t1_busy_b1", 32'(busy), 32'h1);
    send_bit(1'b0, 1'b0);
    check("t1_busy_b2", 32'(busy), 32'h1);
    check("t1_nvalid",  32'(p_valid), 32'h0);
    send_bit(1'b1, 1'b0);
    check("t1_busy_b3", 32'(busy), 32'h1);
    send_bit(1'b1, 1'b0);
    check("t1_valid",   32'(p_valid), 32'h1);
    check_word("t1_word");
    check("t1_busy_end", 32'(busy), 32'h0);
    tick();
    check("t1_valid_drop", 32'(p_valid), 32'h0);
    check("t1_p_out_keep", 32'(p_out), 32'hB);

    // Gapped strobes 1,0,1,1 with 3 idle cycles between bits
    exp_q.push_back(4'hB);
    send_bit(1'b1, 1'b1);
    idle(3);
    check("t2_gap_busy", 32'(busy), 32'h1);
    send_bit(1'b0, 1'b0);
    idle(3);
    check("t2_gap_valid", 32'(p_valid), 32'h0);
    send_bit(1'b1, 1'b0);
    idle(3);
    check("t2_gap_busy2", 32'(busy), 32'h1);
    check("t2_gap_valid2", 32'(p_valid), 32'h0);
    send_bit(1'b1, 1'b0);
    check("t2_valid", 32'(p_valid), 32'h1);
    check_word("t2_word");
    tick();

    // Back-to-back A then 5 with backpressure
    p_ready = 1'b0;
    exp_q.push_back(4'hA);
    send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
    check("t3_valid_a", 32'(p_valid), 32'h1);
    check("t3_ovr_a",   32'(overrun), 32'h0);
    send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
    check("t3_ovr_early", 32'(overrun), 32'h0);
    send_bit(1'b1, 1'b0);
    check("t3_ovr_pulse", 32'(overrun), 32'h1);
    check_word("t3_word_held");
    check("t3_state", 32'(dbg_state), 32'h1);
    tick();
    check("t3_ovr_clear", 32'(overrun), 32'h0);
    check("t3_valid_hold", 32'(p_valid), 32'h1);
    p_ready = 1'b1;
    tick();
    check("t3_valid_drop", 32'(p_valid), 32'h0);
    check("t3_p_out_a", 32'(p_out), 32'hA);

    // Accept-on-completion: 9 held, 3 completes while p_ready=1
    p_ready = 1'b0;
    exp_q.push_back(4'h9);
    send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    check_word("t4_word9");
    exp_q.push_back(4'h3);
    send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    p_ready = 1'b1;
    send_bit(1'b1, 1'b0);
    check_word("t4_word3");
    check("t4_valid", 32'(p_valid), 32'h1);
    check("t4_ovr",   32'(overrun), 32'h0);
    tick();
    check("t4_valid_drop", 32'(p_valid), 32'h0);

    // Re-alignment: 1,1 then frame_start 0,1,1,0 -> 6
    exp_q.push_back(4'h6);
    send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    check("t5_realign_busy", 32'(busy), 32'h1);
    check("t5_realign_ovr",  32'(overrun), 32'h0);
    send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
    check("t5_no_early", 32'(p_valid), 32'h0);
    send_bit(1'b0, 1'b0);
    check_word("t5_word");
    check("t5_valid", 32'(p_valid), 32'h1);
    check("t5_ovr",   32'(overrun), 32'h0);
    tick();

    // Reset mid-word with a held word pending
    p_ready = 1'b0;
    exp_q.push_back(4'hC);
    send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b0);
    check_word("t6_word_c");
    send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b0);
    check("t6_busy_pre", 32'(busy), 32'h1);
    rst = 1'b1;
    s_en = 1'b1; frame_start = 1'b1; s_in = 1'b1;
    tick();
    rst = 1'b0; s_en = 1'b0; frame_start = 1'b0; s_in = 1'b0;
    check("t6_valid", 32'(p_valid),   32'h0);
    check("t6_p_out", 32'(p_out),     32'h0);
    check("t6_busy",  32'(busy),      32'h0);
    check("t6_state", 32'(dbg_state), 32'h0);
    send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
    check("t6_ign_state", 32'(dbg_state), 32'h0);
    check("t6_ign_valid", 32'(p_valid),   32'h0);
    check("t6_ign_busy",  32'(busy),      32'h0);
    check("t6_ign_p_out", 32'(p_out),     32'h0);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
